// File: rtl/jogador_auto.sv
// Automatic player: probes with a guess, derives the secret from the hint
// mask, confirms it with a second guess and retries if the secret moved.
module jogador_auto #(
    parameter int W         = 6,
    parameter int HINT_WAIT = 2,
    parameter int MAX_TENT  = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] dica,
    output logic         enter,
    output logic [W-1:0] tentativa,
    output logic [W-1:0] senha_encontrada,
    output logic [2:0]   num_tent,
    output logic         busy,
    output logic         done,
    output logic         fail
);

    localparam int CW = (HINT_WAIT > 1) ? $clog2(HINT_WAIT) : 1;
    localparam logic [CW-1:0] WLAST = CW'(HINT_WAIT - 1);
    localparam logic [2:0] MAXT = 3'(MAX_TENT);

    typedef enum logic [2:0] {
        IDLE,
        PROBE,
        WAIT_P,
        CONFIRM,
        WAIT_C,
        DONE,
        FAIL
    } state_t;

    state_t state, state_n;

    logic [W-1:0]  cand;
    logic [CW-1:0] wcnt;
    logic          wait_end;
    logic          budget_ok;
    logic          hint_ok;

    assign wait_end  = (wcnt == WLAST);
    assign budget_ok = (num_tent != MAXT);
    assign hint_ok   = &dica;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        enter   = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: begin
                if (go) state_n = PROBE;
            end
            PROBE: begin
                if (!budget_ok) begin
                    state_n = FAIL;
                end else begin
                    enter   = 1'b1;
                    state_n = WAIT_P;
                end
            end
            WAIT_P: begin
                if (wait_end) state_n = CONFIRM;
            end
            CONFIRM: begin
                if (!budget_ok) begin
                    state_n = FAIL;
                end else begin
                    enter   = 1'b1;
                    state_n = WAIT_C;
                end
            end
            WAIT_C: begin
                if (wait_end) state_n = hint_ok ? DONE : PROBE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Wait counter runs only inside WAIT_* and restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if ((state == WAIT_P || state == WAIT_C) && !wait_end) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand             <= '0;
            tentativa        <= '0;
            senha_encontrada <= '0;
            num_tent         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fail             <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE, FAIL: begin
                    if (go) begin
                        num_tent  <= '0;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        tentativa <= '0;
                        busy      <= 1'b1;
                    end
                end
                PROBE, CONFIRM: begin
                    if (budget_ok) begin
                        num_tent <= num_tent + 3'd1;
                    end else begin
                        fail <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                WAIT_P: begin
                    if (wait_end) begin
                        cand      <= tentativa ~^ dica;
                        tentativa <= tentativa ~^ dica;
                    end
                end
                WAIT_C: begin
                    if (wait_end) begin
                        if (hint_ok) begin
                            senha_encontrada <= tentativa;
                            done             <= 1'b1;
                            busy             <= 1'b0;
                        end else begin
                            tentativa <= cand;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jogador_auto.sv
// Directed bench for jogador_auto against a registered hint model
// (dica = secret ~^ guess, latched on the enter edge).
module tb_jogador_auto;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [W-1:0] dica;
    logic         enter;
    logic [W-1:0] tentativa;
    logic [W-1:0] senha_encontrada;
    logic [2:0]   num_tent;
    logic         busy;
    logic         done;
    logic         fail;

    logic [W-1:0] secret;
    logic         toggle;
    logic         flip;
    int           npulse;
    int           ncheck;
    int           npass;
    int           p0;

    jogador_auto #(
        .W(W),
        .HINT_WAIT(2),
        .MAX_TENT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .go(go),
        .dica(dica),
        .enter(enter),
        .tentativa(tentativa),
        .senha_encontrada(senha_encontrada),
        .num_tent(num_tent),
        .busy(busy),
        .done(done),
        .fail(fail)
    );

    always #5 clk = ~clk;

    // Hint source; in toggle mode the secret inverts after every pulse.
    initial begin
        dica   = '0;
        flip   = 1'b0;
        npulse = 0;
    end

    always @(posedge clk) begin
        if (enter) begin
            dica   <= (secret ^ {W{flip}}) ~^ tentativa;
            npulse <= npulse + 1;
            if (toggle) flip <= ~flip;
        end else if (!toggle) begin
            flip <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        ncheck = 0;
        npass  = 0;
        rst    = 1'b1;
        go     = 1'b1;
        toggle = 1'b0;
        secret = 6'b101101;

        // reset held with go asserted
        step(3);
        chk("rst_enter", 8'(enter), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done_fail", 8'({done, fail}), 8'd0);
        chk("rst_num", 8'(num_tent), 8'd0);
        chk("rst_tent", 8'(tentativa), 8'd0);
        chk("rst_senha", 8'(senha_encontrada), 8'd0);
        chk("rst_pulses", 8'(npulse), 8'd0);
        rst = 1'b0;
        go  = 1'b0;
        step(3);
        chk("idle_busy", 8'(busy), 8'd0);
        chk("idle_pulses", 8'(npulse), 8'd0);

        // clean solve, secret 101101
        p0 = npulse;
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("c1_enter", 8'(enter), 8'd1);
        chk("c1_tent", 8'(tentativa), 8'b000000);
        chk("c1_busy", 8'(busy), 8'd1);
        step(1);
        chk("c2_enter", 8'(enter), 8'd0);
        chk("c2_num", 8'(num_tent), 8'd1);
        chk("c2_dica", 8'(dica), 8'b010010);
        step(2);
        chk("c4_enter", 8'(enter), 8'd1);
        chk("c4_tent", 8'(tentativa), 8'b101101);
        step(2);
        chk("c6_done", 8'(done), 8'd0);
        step(1);
        chk("c7_done", 8'(done), 8'd1);
        chk("c7_busy", 8'(busy), 8'd0);
        chk("c7_senha", 8'(senha_encontrada), 8'b101101);
        chk("c7_num", 8'(num_tent), 8'd2);
        chk("c7_pulses", 8'(npulse - p0), 8'd2);

        // go in DONE restarts; secret moves to 000111 after the probe
        p0 = npulse;
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("r1_done", 8'(done), 8'd0);
        chk("r1_enter", 8'(enter), 8'd1);
        chk("r1_tent", 8'(tentativa), 8'b000000);
        chk("r1_busy", 8'(busy), 8'd1);
        step(1);
        secret = 6'b000111;
        go     = 1'b1;
        step(1);
        go = 1'b0;
        chk("r3_enter", 8'(enter), 8'd0);
        chk("r3_num", 8'(num_tent), 8'd1);
        step(1);
        chk("r4_enter", 8'(enter), 8'd1);
        chk("r4_tent", 8'(tentativa), 8'b101101);
        step(1);
        chk("r5_dica", 8'(dica), 8'b010101);
        step(2);
        chk("r7_done", 8'(done), 8'd0);
        chk("r7_enter", 8'(enter), 8'd1);
        chk("r7_tent", 8'(tentativa), 8'b101101);
        chk("r7_num", 8'(num_tent), 8'd2);
        step(3);
        chk("r10_enter", 8'(enter), 8'd1);
        chk("r10_tent", 8'(tentativa), 8'b000111);
        step(3);
        chk("r13_done", 8'(done), 8'd1);
        chk("r13_num", 8'(num_tent), 8'd4);
        chk("r13_senha", 8'(senha_encontrada), 8'b000111);
        chk("r13_pulses", 8'(npulse - p0), 8'd4);

        // asynchronous reset inside WAIT_C
        go = 1'b1;
        step(1);
        go = 1'b0;
        step(4);
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 8'(busy), 8'd0);
        chk("ar_num", 8'(num_tent), 8'd0);
        chk("ar_tent", 8'(tentativa), 8'd0);
        chk("ar_senha", 8'(senha_encontrada), 8'd0);
        chk("ar_done", 8'(done), 8'd0);
        step(1);
        rst = 1'b0;
        step(1);
        p0 = npulse;
        go = 1'b1;
        step(1);
        go = 1'b0;
        chk("f1_enter", 8'(enter), 8'd1);
        step(1);
        chk("f2_num", 8'(num_tent), 8'd1);
        step(5);
        chk("f7_done", 8'(done), 8'd1);
        chk("f7_senha", 8'(senha_encontrada), 8'b000111);
        chk("f7_num", 8'(num_tent), 8'd2);

        // budget exhaustion with the secret inverting every pulse
        toggle = 1'b1;
        p0     = npulse;
        go     = 1'b1;
        step(1);
        go = 1'b0;
        step(12);
        chk("b13_enter", 8'(enter), 8'd0);
        chk("b13_num", 8'(num_tent), 8'd4);
        step(1);
        chk("b14_fail", 8'(fail), 8'd1);
        chk("b14_done", 8'(done), 8'd0);
        chk("b14_busy", 8'(busy), 8'd0);
        step(4);
        chk("b18_num", 8'(num_tent), 8'd4);
        chk("b18_pulses", 8'(npulse - p0), 8'd4);
        chk("b18_fail", 8'(fail), 8'd1);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/jogador_auto.md
# jogador_auto

Automatic player for the password-hint game. Where the hint block turns a player's guess into a per-bit match mask, this block sits on the guessing side. It pulses `enter` with a guess on `tentativa`, reads back the `dica` mask, and works out the secret from it. It then confirms the result with a second guess and retries if the secret changes mid-solve. It reports the recovered secret, the attempt count and a done or fail status for display on LEDG/HEX.

## Interface

Parameters:
- `W`, default 6: secret, guess and hint width.
- `HINT_WAIT`, default 2: cycles from the `enter` pulse to `dica` sampling. Must be ≥1.
- `MAX_TENT`, default 6: attempt budget. Range 2..7.

Ports:
- `clk`, in, 1: the only clock. Everything is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `go`, in, 1: one-cycle request to start a solve.
- `dica`, in, W: hint mask. Bit = 1 when the guess bit equals the secret bit.
- `enter`, out, 1: one-cycle pulse that submits `tentativa`.
- `tentativa`, out, W: current guess.
- `senha_encontrada`, out, W: secret recovered on success.
- `num_tent`, out, 3: number of `enter` pulses issued in this solve.
- `busy`, out, 1: high from the `go` acceptance edge until `done` or `fail` asserts.
- `done`, out, 1: sticky success flag.
- `fail`, out, 1: sticky failure flag.

## Operation

- Reset value of every output is 0. Reset returns the FSM to IDLE and clears the internal wait counter and candidate register.
- FSM states: IDLE, PROBE, WAIT_P, CONFIRM, WAIT_C, DONE, FAIL.
- IDLE, DONE, FAIL: `go` = 1 moves to PROBE.
  - `num_tent`, `done`, `fail` clear to 0; `tentativa` loads 0; `busy` sets.
  - `senha_encontrada` is not cleared.
- PROBE:
  - If `num_tent` == `MAX_TENT`: go to FAIL, with no pulse.
  - Otherwise: `enter` = 1 for this cycle, `num_tent` += 1, go to WAIT_P.
- WAIT_P: stays for `HINT_WAIT` cycles. On the final edge:
  - `cand` ← `tentativa ~^ dica`;
  - `tentativa` ← `cand`;
  - go to CONFIRM.
- CONFIRM: same budget check as PROBE. If the budget allows, pulse `enter` and increment `num_tent`, then go to WAIT_C.
- WAIT_C: stays `HINT_WAIT` cycles. On the final edge:
  - `dica` all ones: `senha_encontrada` ← `tentativa`, `done` ← 1, `busy` ← 0, go to DONE.
  - Otherwise (the secret changed): go to PROBE, keeping `tentativa` = `cand` as the new probe value.
- FAIL: `fail` ← 1 and `busy` ← 0 on entry.
- `go` while `busy` is ignored.
- `tentativa` is held constant from the `enter` cycle through the `dica` sampling edge.
- `num_tent` never exceeds `MAX_TENT`.
- `done` and `fail` are never both high.

## Timing

- With `go` sampled at edge E0, and the default `HINT_WAIT` = 2, a clean solve runs as follows:
  - Probe `enter` is high in cycle 1.
  - `dica` is sampled at the end of cycle 3.
  - Confirm `enter` is high in cycle 4, with `tentativa` = `cand`.
  - Sample at the end of cycle 6.
  - `done` = 1 from cycle 7.
- General clean-solve latency is 2·(`HINT_WAIT`+1)+1 cycles.
- Each retry round adds 2·(`HINT_WAIT`+1) cycles.
- Two `enter` pulses are always separated by at least `HINT_WAIT` low cycles.
- `rst` asserted in any state (including WAIT_*) forces all outputs to 0 immediately, without waiting for `clk`. The FSM resumes from IDLE on the first edge after release.
- `dica` changing outside the sampling edge has no effect.

## Test plan

- Reset: hold `rst`, drive `go` = 1 → all outputs 0, no `enter`. Release `rst` → IDLE until `go`.
- Clean solve, secret 101101, hint model `dica` = secret ~^ latched guess (registered one cycle after `enter`):
  - probe 000000 → `dica` 010010;
  - confirm 101101 → `dica` 111111;
  - `done` = 1 in cycle 7, `senha_encontrada` = 101101, `num_tent` = 2, `busy` = 0.
- Secret changed to 000111 after the probe:
  - confirm 101101 → `dica` 010101;
  - re-probe 101101 → `cand` 000111;
  - confirm → 111111, `done`, `num_tent` = 4, `senha_encontrada` = 000111.
- Budget exhaustion, `MAX_TENT` = 4, secret toggled every round → `fail` = 1 after the 4th pulse, `num_tent` = 4, no 5th `enter`, `done` = 0.
- Mid-operation: `rst` pulsed during WAIT_C → outputs 0 asynchronously. Then `go` → a full fresh solve with `num_tent` restarting at 1.
- `go` pulsed while `busy` → no restart, pulse spacing unchanged. `go` in DONE → `done` clears, new solve begins.
